efc_transition_scheduler: RTL and testbench
===========================================

EFC_TRANSITION_SCHEDULER -- requirements
Module: efc_transition_scheduler

Interface
REQ-001 Parameter N_TRANS, default 2: number of transitions in one free-choice conflict set; legal range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in clock cycles; legal range 2..65535.
REQ-003 Parameter CNT_W, default 16: width of the firing counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_TRANS  bit i: environment requests transition ti.
REQ-007 enabled  input  N_TRANS  bit i: barrier condition of ti true (all input places of ti marked in every FSM).
REQ-008 choice_place  input  1  choice place of the conflict set is marked.
REQ-009 fire  output  N_TRANS  one-hot firing pulse, drives the FSM tI_ inputs.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 last_grant  output  4  index of the most recently fired transition.
REQ-012 fire_count  output  CNT_W  number of firings since reset.
REQ-013 timeout_err  output  1  sticky watchdog flag.

Function
REQ-014 States: IDLE, FIRE, LEAVE, RETURN; encoding is one-hot.
REQ-015 IDLE: cand = req & enabled, qualified by choice_place=1; if cand is non-zero, grant = first set bit of cand searched upward from ptr, wrapping modulo N_TRANS; registered into fire; next state FIRE.
REQ-016 Latency: fire is asserted on the cycle after the one in which cand was non-zero in IDLE.
REQ-017 FIRE: fire equals onehot(grant) for exactly one cycle; ptr <= (grant+1) mod N_TRANS; last_grant <= grant; fire_count increments, wrapping to 0 from all-ones; next state LEAVE.
REQ-018 fire is all-zero in every state except FIRE; at most one bit is set in any cycle.
REQ-019 The grant is final once registered; deassertion of req or enabled during FIRE does not suppress the pulse.
REQ-020 LEAVE: wait for choice_place=0 (token consumed), then go to RETURN.
REQ-021 RETURN: wait for choice_place=1 (token returned), then go to IDLE; no arbitration occurs in the same cycle.
REQ-022 Round-robin fairness: under continuous requests on all N_TRANS transitions, each transition fires once in every N_TRANS firings.
REQ-023 ptr never points outside 0..N_TRANS-1; with a single candidate, that candidate is granted regardless of ptr.

Reset
REQ-024 On reset: state IDLE, fire=0, busy=0, last_grant=0, ptr=0, fire_count=0, timeout_err=0, watchdog counter=0.
REQ-025 Reset asserted mid-operation (any state) takes effect at the next edge; no fire pulse is produced on that edge; reset has priority over all inputs.

Configuration
REQ-026 Macro EFC_SCHED_WATCHDOG_EN, defined: the watchdog counter clears on entry to LEAVE and counts every cycle in LEAVE and RETURN; on reaching TIMEOUT_CYCLES the block sets timeout_err (held until reset) and moves to IDLE on the next cycle.
REQ-027 Macro EFC_SCHED_WATCHDOG_EN, undefined: no watchdog counter is present; timeout_err is constant 0; LEAVE and RETURN wait indefinitely.

Verification
REQ-028 Reset then req=2'b01, enabled=2'b01, choice_place=1 -> fire=2'b01 one cycle after the request cycle, for one cycle only; fire_count=1; last_grant=0.
REQ-029 req=2'b11, enabled=2'b11 held, choice_place toggled 1->0->1 after each fire -> fire sequence 01, 10, 01, 10; ptr alternates.
REQ-030 req=2'b11, enabled=2'b10 -> only fire=2'b10 is issued; t0 never fires while its enable is low.
REQ-031 Watchdog macro defined, TIMEOUT_CYCLES=8, choice_place stuck at 1 after a fire -> timeout_err=1 exactly 8 cycles after entry to LEAVE, then busy=0; macro undefined -> busy stays 1 and timeout_err=0.
REQ-032 Reset asserted in the FIRE cycle -> fire=0 and busy=0 on the following cycle; fire_count=0.
REQ-033 CNT_W=4, 17 completed firings -> fire_count wraps to 1.

Source files
------------

// File: rtl/efc_transition_scheduler.sv
// -----------------------------------------------------------------------------
// efc_transition_scheduler
//
// Arbitrates among the transitions of one free-choice conflict set. When the
// shared choice place is marked and at least one transition is both requested
// and enabled, one is granted round-robin and a single-cycle one-hot fire pulse
// is issued. The scheduler then waits for the choice-place token to be consumed
// (LEAVE) and returned (RETURN) before arbitrating again.
//
// Optional feature: define EFC_SCHED_WATCHDOG_EN to add a watchdog that bounds
// the time spent in LEAVE/RETURN to TIMEOUT_CYCLES. On expiry it sets the
// sticky timeout_err flag and returns to IDLE. Without the macro there is no
// watchdog, timeout_err is tied to 0, and LEAVE/RETURN wait indefinitely.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   req          in   [N_TRANS] environment requests per transition
//   enabled      in   [N_TRANS] barrier condition per transition
//   choice_place in   choice place of the conflict set is marked
//   fire         out  [N_TRANS] one-hot firing pulse (one cycle)
//   busy         out  high in every state except IDLE
//   last_grant   out  [4] index of most recently fired transition
//   fire_count   out  [CNT_W] firings since reset (wraps)
//   timeout_err  out  sticky watchdog flag
// -----------------------------------------------------------------------------
module efc_transition_scheduler #(
   parameter int N_TRANS        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_TRANS-1:0] req,
   input  logic [N_TRANS-1:0] enabled,
   input  logic               choice_place,
   output logic [N_TRANS-1:0] fire,
   output logic               busy,
   output logic [3:0]         last_grant,
   output logic [CNT_W-1:0]   fire_count,
   output logic               timeout_err
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_FIRE   = 4'b0010,
      S_LEAVE  = 4'b0100,
      S_RETURN = 4'b1000
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [N_TRANS-1:0] cand_s;
   logic [N_TRANS-1:0] onehot_s;
   logic [3:0]         sel_s;
   logic               found_s;
   logic               wd_expired_s;
   logic [3:0]         grant_r;
   logic [3:0]         ptr_r;
   logic [N_TRANS-1:0] fire_r;
   logic               busy_r;
   logic [3:0]         last_grant_r;
   logic [CNT_W-1:0]   fire_count_r;

   // Candidates only count while the choice place holds its token.
   assign cand_s   = choice_place ? (req & enabled) : {N_TRANS{1'b0}};
   assign onehot_s = {{(N_TRANS-1){1'b0}}, 1'b1} << sel_s;

   // Round-robin search: first candidate at or above ptr, wrapping modulo N_TRANS.
   always_comb begin
      int idx;
      sel_s   = 4'd0;
      found_s = 1'b0;
      idx     = 0;
      for (int k = 0; k < N_TRANS; k++) begin
         idx = int'(ptr_r) + k;
         if (idx >= N_TRANS) begin
            idx = idx - N_TRANS;
         end else begin
            idx = idx;
         end
         if (!found_s && cand_s[idx]) begin
            found_s = 1'b1;
            sel_s   = 4'(idx);
         end else begin
            found_s = found_s;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; watchdog expiry overrides the token handshake.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (found_s) state_next_s = S_FIRE;
            else         state_next_s = S_IDLE;
         end
         S_FIRE: begin
            state_next_s = S_LEAVE;
         end
         S_LEAVE: begin
            if (wd_expired_s)       state_next_s = S_IDLE;
            else if (!choice_place) state_next_s = S_RETURN;
            else                    state_next_s = S_LEAVE;
         end
         S_RETURN: begin
            if (wd_expired_s)      state_next_s = S_IDLE;
            else if (choice_place) state_next_s = S_IDLE;
            else                   state_next_s = S_RETURN;
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // Grant capture, fire pulse and firing bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_r      <= 4'd0;
         ptr_r        <= 4'd0;
         fire_r       <= {N_TRANS{1'b0}};
         busy_r       <= 1'b0;
         last_grant_r <= 4'd0;
         fire_count_r <= {CNT_W{1'b0}};
      end else begin
         busy_r <= (state_next_s != S_IDLE);
         case (state_r)
            S_IDLE: begin
               if (found_s) begin
                  grant_r <= sel_s;
                  fire_r  <= onehot_s;
               end else begin
                  fire_r  <= {N_TRANS{1'b0}};
               end
            end
            S_FIRE: begin
               // The grant is committed; the pulse is already on fire_r.
               fire_r       <= {N_TRANS{1'b0}};
               last_grant_r <= grant_r;
               fire_count_r <= fire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (grant_r == 4'(N_TRANS - 1)) ptr_r <= 4'd0;
               else                            ptr_r <= grant_r + 4'd1;
            end
            default: begin
               fire_r <= {N_TRANS{1'b0}};
            end
         endcase
      end
   end

`ifdef EFC_SCHED_WATCHDOG_EN
   logic [15:0] wd_r;
   logic        timeout_err_r;

   // Counter saturates at TIMEOUT_CYCLES; that value forces the exit to IDLE.
   assign wd_expired_s = (wd_r == 16'(TIMEOUT_CYCLES));

   // Watchdog: cleared on entry to LEAVE, counts through LEAVE and RETURN.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_r          <= 16'd0;
         timeout_err_r <= 1'b0;
      end else if (state_r == S_FIRE) begin
         wd_r <= 16'd0;
      end else if ((state_r == S_LEAVE) || (state_r == S_RETURN)) begin
         if (wd_r == 16'(TIMEOUT_CYCLES - 1)) begin
            wd_r          <= 16'(TIMEOUT_CYCLES);
            timeout_err_r <= 1'b1;
         end else if (!wd_expired_s) begin
            wd_r <= wd_r + 16'd1;
         end else begin
            wd_r <= wd_r;
         end
      end else begin
         wd_r <= wd_r;
      end
   end

   assign timeout_err = timeout_err_r;
`else
   assign wd_expired_s = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   assign fire       = fire_r;
   assign busy       = busy_r;
   assign last_grant = last_grant_r;
   assign fire_count = fire_count_r;

endmodule

// File: tb/tb_efc_transition_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for efc_transition_scheduler: a cycle-by-cycle vector table plus
// hand-written sequences for counter wrap, fairness and the watchdog.
// A second instance with CNT_W=4 shares the stimulus to observe counter wrap.
// -----------------------------------------------------------------------------
module tb_efc_transition_scheduler;

`ifdef EFC_SCHED_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] req;
   logic [1:0] enabled;
   logic       choice_place;
   logic [1:0] fire;
   logic       busy;
   logic [3:0] last_grant;
   logic [15:0] fire_count;
   logic       timeout_err;
   logic [1:0] fire_s;
   logic       busy_s;
   logic [3:0] last_grant_s;
   logic [3:0] fire_count_s;
   logic       timeout_err_s;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  en;
      logic        cp;
      logic [1:0]  fire;
      logic        busy;
      logic [3:0]  lg;
      logic [15:0] cnt;
   } vec_t;

   vec_t vq[$];

   efc_transition_scheduler #(.N_TRANS(2), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .req(req), .enabled(enabled),
      .choice_place(choice_place), .fire(fire), .busy(busy),
      .last_grant(last_grant), .fire_count(fire_count), .timeout_err(timeout_err)
   );

   efc_transition_scheduler #(.N_TRANS(2), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .req(req), .enabled(enabled),
      .choice_place(choice_place), .fire(fire_s), .busy(busy_s),
      .last_grant(last_grant_s), .fire_count(fire_count_s), .timeout_err(timeout_err_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] en,
                      input logic cp, input logic [1:0] f, input logic b,
                      input logic [3:0] lg, input logic [15:0] cnt);
      vec_t v;
      v.rst = r; v.req = rq; v.en = en; v.cp = cp;
      v.fire = f; v.busy = b; v.lg = lg; v.cnt = cnt;
      vq.push_back(v);
   endtask

   initial begin
      reset = 1'b1; req = 2'b00; enabled = 2'b00; choice_place = 1'b1;
      //   rst req    en     cp    fire   busy lg    cnt
      add(1, 2'b00, 2'b00, 1'b1, 2'b00, 0, 4'd0, 16'd0);  // reset state
      add(0, 2'b01, 2'b01, 1'b1, 2'b01, 1, 4'd0, 16'd0);  // single request
      add(0, 2'b00, 2'b00, 1'b1, 2'b00, 1, 4'd0, 16'd1);  // FIRE -> LEAVE
      add(0, 2'b00, 2'b00, 1'b1, 2'b00, 1, 4'd0, 16'd1);  // LEAVE holds
      add(0, 2'b00, 2'b00, 1'b0, 2'b00, 1, 4'd0, 16'd1);  // -> RETURN
      add(0, 2'b00, 2'b00, 1'b1, 2'b00, 0, 4'd0, 16'd1);  // -> IDLE
      add(0, 2'b11, 2'b11, 1'b1, 2'b10, 1, 4'd0, 16'd1);  // ptr=1 -> t1
      add(0, 2'b11, 2'b11, 1'b1, 2'b00, 1, 4'd1, 16'd2);
      add(0, 2'b11, 2'b11, 1'b0, 2'b00, 1, 4'd1, 16'd2);
      add(0, 2'b11, 2'b11, 1'b1, 2'b00, 0, 4'd1, 16'd2);  // no arbitration in RETURN
      add(0, 2'b11, 2'b11, 1'b1, 2'b01, 1, 4'd1, 16'd2);  // t0
      add(0, 2'b11, 2'b11, 1'b1, 2'b00, 1, 4'd0, 16'd3);
      add(0, 2'b11, 2'b11, 1'b0, 2'b00, 1, 4'd0, 16'd3);
      add(0, 2'b11, 2'b11, 1'b1, 2'b00, 0, 4'd0, 16'd3);
      add(0, 2'b11, 2'b11, 1'b1, 2'b10, 1, 4'd0, 16'd3);  // t1
      add(0, 2'b11, 2'b11, 1'b1, 2'b00, 1, 4'd1, 16'd4);
      add(0, 2'b11, 2'b11, 1'b0, 2'b00, 1, 4'd1, 16'd4);
      add(0, 2'b11, 2'b11, 1'b1, 2'b00, 0, 4'd1, 16'd4);
      add(0, 2'b11, 2'b10, 1'b1, 2'b10, 1, 4'd1, 16'd4);  // ptr=0, t0 disabled
      add(0, 2'b11, 2'b10, 1'b1, 2'b00, 1, 4'd1, 16'd5);
      add(0, 2'b11, 2'b10, 1'b0, 2'b00, 1, 4'd1, 16'd5);
      add(0, 2'b11, 2'b10, 1'b1, 2'b00, 0, 4'd1, 16'd5);
      add(0, 2'b11, 2'b10, 1'b1, 2'b10, 1, 4'd1, 16'd5);  // t1 again
      add(0, 2'b11, 2'b10, 1'b1, 2'b00, 1, 4'd1, 16'd6);
      add(0, 2'b11, 2'b10, 1'b0, 2'b00, 1, 4'd1, 16'd6);
      add(0, 2'b11, 2'b10, 1'b1, 2'b00, 0, 4'd1, 16'd6);
      add(0, 2'b11, 2'b11, 1'b0, 2'b00, 0, 4'd1, 16'd6);  // no token: no fire
      add(0, 2'b01, 2'b01, 1'b1, 2'b01, 1, 4'd1, 16'd6);
      add(0, 2'b00, 2'b00, 1'b1, 2'b00, 1, 4'd0, 16'd7);  // req dropped in FIRE
      add(0, 2'b00, 2'b00, 1'b0, 2'b00, 1, 4'd0, 16'd7);
      add(0, 2'b00, 2'b00, 1'b1, 2'b00, 0, 4'd0, 16'd7);
      add(0, 2'b01, 2'b01, 1'b1, 2'b01, 1, 4'd0, 16'd7);  // ptr=1, sole cand t0
      add(1, 2'b01, 2'b01, 1'b1, 2'b00, 0, 4'd0, 16'd0);  // reset during FIRE

      for (int i = 0; i < vq.size(); i++) begin
         reset = vq[i].rst; req = vq[i].req; enabled = vq[i].en; choice_place = vq[i].cp;
         step();
         check($sformatf("v%0d fire", i), 32'(fire), 32'(vq[i].fire));
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].busy));
         check($sformatf("v%0d last_grant", i), 32'(last_grant), 32'(vq[i].lg));
         check($sformatf("v%0d fire_count", i), 32'(fire_count), 32'(vq[i].cnt));
         check($sformatf("v%0d small_count", i), 32'(fire_count_s), 32'(vq[i].cnt[3:0]));
         check($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'd0);
      end

      // 17 firings under continuous requests: alternation and counter wrap.
      reset = 1'b0; req = 2'b11; enabled = 2'b11;
      for (int i = 0; i < 17; i++) begin
         choice_place = 1'b1;
         step();
         check($sformatf("rr%0d fire", i), 32'(fire), (i % 2 == 0) ? 32'd1 : 32'd2);
         step();
         check($sformatf("rr%0d last_grant", i), 32'(last_grant), 32'(i % 2));
         choice_place = 1'b0;
         step();
         choice_place = 1'b1;
         step();
      end
      check("wrap big_count", 32'(fire_count), 32'd17);
      check("wrap small_count", 32'(fire_count_s), 32'd1);

      // Choice place stuck at 1 after a fire: watchdog behaviour.
      req = 2'b10; enabled = 2'b10; choice_place = 1'b1;
      step();
      check("wd fire", 32'(fire), 32'd2);
      req = 2'b00; enabled = 2'b00;
      step();                                  // entry to LEAVE
      for (int k = 1; k <= 7; k++) step();
      check("wd pre timeout_err", 32'(timeout_err), 32'd0);
      check("wd pre busy", 32'(busy), 32'd1);
      step();                                  // 8 cycles after entry
      check("wd timeout_err", 32'(timeout_err), 32'(WD_EN));
      check("wd busy at expiry", 32'(busy), 32'd1);
      step();
      check("wd busy after", 32'(busy), WD_EN ? 32'd0 : 32'd1);
      check("wd timeout_err held", 32'(timeout_err), 32'(WD_EN));
      choice_place = 1'b0;
      step();
      choice_place = 1'b1;
      step();
      check("wd idle busy", 32'(busy), 32'd0);
      check("wd sticky", 32'(timeout_err), 32'(WD_EN));
      check("wd count", 32'(fire_count), 32'd18);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
